pipelined_decode_stage: RTL

Decode stage for the 5-stage pipelined core. It contains the writeback data mux, a parametrised register file with write-through bypass, immediate generation, EX/MEM forwarding and load-use hazard detection. It ends in the ID/EX pipeline register, which supports stall and flush. It sits between the IF/ID register and the execute stage.

---
 rtl/pipelined_decode_stage_if.sv | 53 +++++
 rtl/pipelined_decode_stage.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/pipelined_decode_stage_if.sv
// Decode-stage bundle: IF/ID, EX/MEM/WB feedback and ID/EX outputs.
// The slave side is the decode stage; the master side is the surrounding pipeline.
interface pipelined_decode_stage_if #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
);
    logic [31:0]     inst_i;
    logic [XLEN-1:0] pc_i;
    logic            if_valid_i;
    logic [2:0]      imm_sel_i;
    logic            flush_i;
    logic            ex_we_i;
    logic [RA_W-1:0] ex_wr_i;
    logic            ex_is_load_i;
    logic [XLEN-1:0] ex_result_i;
    logic            mem_we_i;
    logic [RA_W-1:0] mem_wr_i;
    logic [XLEN-1:0] mem_result_i;
    logic            wb_we_i;
    logic [RA_W-1:0] wb_wr_i;
    logic [1:0]      wb_sel_i;
    logic [XLEN-1:0] wb_pc4_i;
    logic [XLEN-1:0] wb_alu_i;
    logic [XLEN-1:0] wb_mem_i;
    logic            stall_o;
    logic            id_valid_o;
    logic [XLEN-1:0] id_pc_o;
    logic [XLEN-1:0] id_rD1_o;
    logic [XLEN-1:0] id_rD2_o;
    logic [XLEN-1:0] id_ext_o;
    logic [RA_W-1:0] id_wr_o;
    logic            wb_we_o;
    logic [RA_W-1:0] wb_wR_o;
    logic [XLEN-1:0] wb_wD_o;

    modport master (
        output inst_i, pc_i, if_valid_i, imm_sel_i, flush_i,
               ex_we_i, ex_wr_i, ex_is_load_i, ex_result_i,
               mem_we_i, mem_wr_i, mem_result_i,
               wb_we_i, wb_wr_i, wb_sel_i, wb_pc4_i, wb_alu_i, wb_mem_i,
        input  stall_o, id_valid_o, id_pc_o, id_rD1_o, id_rD2_o, id_ext_o, id_wr_o,
               wb_we_o, wb_wR_o, wb_wD_o
    );

    modport slave (
        input  inst_i, pc_i, if_valid_i, imm_sel_i, flush_i,
               ex_we_i, ex_wr_i, ex_is_load_i, ex_result_i,
               mem_we_i, mem_wr_i, mem_result_i,
               wb_we_i, wb_wr_i, wb_sel_i, wb_pc4_i, wb_alu_i, wb_mem_i,
        output stall_o, id_valid_o, id_pc_o, id_rD1_o, id_rD2_o, id_ext_o, id_wr_o,
               wb_we_o, wb_wR_o, wb_wD_o
    );
endinterface

// File: rtl/pipelined_decode_stage.sv
// Decode stage: WB mux, register file with write-through, forwarding, load-use
// hazard detection, immediate generation and the ID/EX register.
module pipelined_decode_stage #(
    parameter int XLEN       = 32,
    parameter int NREG       = 32,
    parameter int RA_W       = 5,
    parameter int FORWARD_EN = 1
) (
    input logic                  clk_i,
    input logic                  reset_i,
    pipelined_decode_stage_if.slave bus
);

    function automatic logic in_range(input logic [RA_W-1:0] a);
        return int'(a) < NREG;
    endfunction

    logic [XLEN-1:0]            wb_wd;
    logic                       wb_we;
    logic [XLEN-1:0]            rf_q [NREG];
    logic [XLEN-1:0]            rf_d [NREG];
    logic [1:0][RA_W-1:0]       rs;
    logic [1:0][XLEN-1:0]       op;
    logic [RA_W-1:0]            rd;
    logic                       load_use, ex_hit, mem_hit, stall_cond;
    logic [XLEN-1:0]            imm;
    logic                       unused_opcode;

    logic                       id_valid_q, id_valid_d;
    logic [XLEN-1:0]            id_pc_q, id_pc_d;
    logic [XLEN-1:0]            id_rd1_q, id_rd1_d;
    logic [XLEN-1:0]            id_rd2_q, id_rd2_d;
    logic [XLEN-1:0]            id_ext_q, id_ext_d;
    logic [RA_W-1:0]            id_wr_q, id_wr_d;

    assign rs[0] = RA_W'(bus.inst_i[19:15]);
    assign rs[1] = RA_W'(bus.inst_i[24:20]);
    assign rd    = RA_W'(bus.inst_i[11:7]);
    assign unused_opcode = ^bus.inst_i[6:0];

    always_comb begin
        wb_wd = '0;
        case (bus.wb_sel_i)
            2'b00:   wb_wd = bus.wb_pc4_i;
            2'b01:   wb_wd = bus.wb_alu_i;
            2'b10:   wb_wd = bus.wb_mem_i;
            default: wb_wd = '0;
        endcase
    end

    assign wb_we = bus.wb_we_i && (bus.wb_sel_i != 2'b11) && (bus.wb_wr_i != '0) && in_range(bus.wb_wr_i);

    always_comb begin
        rf_d = rf_q;
        if (wb_we) rf_d[bus.wb_wr_i] = wb_wd;
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else begin
            rf_q <= rf_d;
        end
    end

    // Operand priority: EX (non-load) > MEM > same-cycle WB > array.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            op[k] = '0;
            if (rs[k] == '0 || !in_range(rs[k]))
                op[k] = '0;
            else if (FORWARD_EN != 0 && bus.ex_we_i && !bus.ex_is_load_i && bus.ex_wr_i == rs[k])
                op[k] = bus.ex_result_i;
            else if (FORWARD_EN != 0 && bus.mem_we_i && bus.mem_wr_i == rs[k])
                op[k] = bus.mem_result_i;
            else if (wb_we && bus.wb_wr_i == rs[k])
                op[k] = wb_wd;
            else
                op[k] = rf_q[rs[k]];
        end
    end

    // rs2 is checked regardless of format; spurious stalls on I/U/J are harmless.
    always_comb begin
        load_use = 1'b0;
        ex_hit   = 1'b0;
        mem_hit  = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (rs[k] != '0) begin
                if (bus.ex_we_i && bus.ex_wr_i == rs[k]) begin
                    ex_hit = 1'b1;
                    if (bus.ex_is_load_i) load_use = 1'b1;
                end
                if (bus.mem_we_i && bus.mem_wr_i == rs[k]) mem_hit = 1'b1;
            end
        end
    end

    assign stall_cond = bus.if_valid_i && (load_use || (FORWARD_EN == 0 && (ex_hit || mem_hit)));

    always_comb begin
        imm = '0;
        case (bus.imm_sel_i)
            3'b000:  imm = XLEN'($signed(bus.inst_i[31:20]));
            3'b001:  imm = XLEN'($signed({bus.inst_i[31:25], bus.inst_i[11:7]}));
            3'b010:  imm = XLEN'($signed({bus.inst_i[31], bus.inst_i[7], bus.inst_i[30:25],
                                          bus.inst_i[11:8], 1'b0}));
            3'b011:  imm = XLEN'($signed({bus.inst_i[31:12], 12'b0}));
            3'b100:  imm = XLEN'($signed({bus.inst_i[31], bus.inst_i[19:12], bus.inst_i[20],
                                          bus.inst_i[30:21], 1'b0}));
            default: imm = '0;
        endcase
    end

    always_comb begin
        id_valid_d = bus.if_valid_i;
        id_wr_d    = rd;
        id_pc_d    = bus.pc_i;
        id_rd1_d   = op[0];
        id_rd2_d   = op[1];
        id_ext_d   = imm;
        if (bus.flush_i || stall_cond) begin
            id_valid_d = 1'b0;
            id_wr_d    = '0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            id_valid_q <= 1'b0;
            id_pc_q    <= '0;
            id_rd1_q   <= '0;
            id_rd2_q   <= '0;
            id_ext_q   <= '0;
            id_wr_q    <= '0;
        end else begin
            id_valid_q <= id_valid_d;
            id_pc_q    <= id_pc_d;
            id_rd1_q   <= id_rd1_d;
            id_rd2_q   <= id_rd2_d;
            id_ext_q   <= id_ext_d;
            id_wr_q    <= id_wr_d;
        end
    end

    assign bus.stall_o    = stall_cond && !bus.flush_i;
    assign bus.id_valid_o = id_valid_q;
    assign bus.id_pc_o    = id_pc_q;
    assign bus.id_rD1_o   = id_rd1_q;
    assign bus.id_rD2_o   = id_rd2_q;
    assign bus.id_ext_o   = id_ext_q;
    assign bus.id_wr_o    = id_wr_q;
    assign bus.wb_we_o    = wb_we;
    assign bus.wb_wR_o    = bus.wb_wr_i;
    assign bus.wb_wD_o    = wb_wd;

endmodule
